// File: rtl/accumulator_bank_if.sv
// accumulator_bank_if
//   Request/response bundle between the systolic-array write-back path and
//   accumulator_bank. Clock and reset stay outside the interface.
//   Parameters: COLS lanes, DATA_W input element width, ACC_W stored width,
//   AW row-address width (must equal $clog2(DEPTH) of the attached bank).
//   slave  : the bank side (takes requests, drives busy/read data/overflow)
//   master : the array / test side
//   Signals: clear_i, busy_o, wr_en_i, acc_mode_i, col_mask_i, addr_wr_i,
//            data_i, rd_en_i, addr_rd_i, data_o, valid_o, ovf_o
interface accumulator_bank_if #(
    parameter int COLS   = 32,
    parameter int DATA_W = 32,
    parameter int ACC_W  = 32,
    parameter int AW     = 7
);
    logic                         clear_i;
    logic                         busy_o;
    logic                         wr_en_i;
    logic                         acc_mode_i;
    logic [COLS-1:0]              col_mask_i;
    logic [AW-1:0]                addr_wr_i;
    logic [COLS-1:0][DATA_W-1:0]  data_i;
    logic                         rd_en_i;
    logic [AW-1:0]                addr_rd_i;
    logic [COLS-1:0][ACC_W-1:0]   data_o;
    logic                         valid_o;
    logic [COLS-1:0]              ovf_o;

    modport slave (
        input  clear_i, wr_en_i, acc_mode_i, col_mask_i, addr_wr_i, data_i,
               rd_en_i, addr_rd_i,
        output busy_o, data_o, valid_o, ovf_o
    );

    modport master (
        output clear_i, wr_en_i, acc_mode_i, col_mask_i, addr_wr_i, data_i,
               rd_en_i, addr_rd_i,
        input  busy_o, data_o, valid_o, ovf_o
    );
endinterface

// File: rtl/accumulator_bank.sv
// accumulator_bank
//   COLS-wide, DEPTH-deep output accumulator for the systolic array. Each
//   column is one lane instance owning its own DEPTH x ACC_W storage. Column c
//   addresses row (addr - c) mod DEPTH on both ports, matching the array skew.
//   Writes overwrite or read-modify-write in one cycle; reads are registered
//   (1-cycle latency, data zero when not valid). A clear engine walks all rows
//   after reset release and on clear_i, blocking traffic while busy.
//   Optional feature macro: ACC_SAT_EN -- signed saturation of accumulation
//   with sticky per-column overflow flags (ovf_o tied low when undefined).
//   Ports: clk_i, rst_ni (async active-low), bus (accumulator_bank_if.slave).

// One column: storage, skewed write RMW, registered skewed read, overflow.
module accumulator_bank_lane #(
    parameter int DEPTH  = 128,
    parameter int DATA_W = 32,
    parameter int ACC_W  = 32,
    parameter int AW     = 7,
    parameter int LANE   = 0
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              clr_en_i,
    input  logic [AW-1:0]     clr_row_i,
`ifdef ACC_SAT_EN
    input  logic              clr_ovf_i,
    output logic              ovf_o,
`endif
    input  logic              wr_en_i,
    input  logic              acc_mode_i,
    input  logic [AW-1:0]     addr_wr_i,
    input  logic [DATA_W-1:0] din_i,
    input  logic              rd_en_i,
    input  logic [AW-1:0]     addr_rd_i,
    output logic [ACC_W-1:0]  dout_o
);
    localparam logic [AW-1:0] SKEW = AW'(LANE);

    logic [ACC_W-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wrow, rrow;
    logic [ACC_W-1:0] ext, old, acc_val, wval;
    logic [ACC_W-1:0] dout_q, dout_d;

    // DEPTH is a power of two, so AW-bit subtraction is the modulo wrap.
    assign wrow = addr_wr_i - SKEW;
    assign rrow = addr_rd_i - SKEW;
    assign ext  = ACC_W'($signed(din_i));
    assign old  = mem_q[wrow];

`ifdef ACC_SAT_EN
    localparam logic [ACC_W-1:0] SAT_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic [ACC_W-1:0] SAT_MIN = {1'b1, {(ACC_W-1){1'b0}}};

    logic [ACC_W:0] sum;
    logic           sat;
    logic           ovf_q;

    // One guard bit: overflow iff the two top bits of the sum disagree;
    // the guard bit then carries the true sign and picks the rail.
    assign sum     = {old[ACC_W-1], old} + {ext[ACC_W-1], ext};
    assign sat     = sum[ACC_W] ^ sum[ACC_W-1];
    assign acc_val = sat ? (sum[ACC_W] ? SAT_MIN : SAT_MAX) : sum[ACC_W-1:0];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni)                              ovf_q <= 1'b0;
        else if (clr_ovf_i)                       ovf_q <= 1'b0;
        else if (wr_en_i && acc_mode_i && sat)    ovf_q <= 1'b1;
    end
    assign ovf_o = ovf_q;
`else
    assign acc_val = old + ext;
`endif

    assign wval = acc_mode_i ? acc_val : ext;

    // Storage has no reset; the clear engine zeroes it after reset release.
    always_ff @(posedge clk_i) begin
        if (clr_en_i)     mem_q[clr_row_i] <= '0;
        else if (wr_en_i) mem_q[wrow]      <= wval;
    end

    // Read samples the array before this edge's write lands: pre-write value.
    assign dout_d = rd_en_i ? mem_q[rrow] : '0;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) dout_q <= '0;
        else         dout_q <= dout_d;
    end
    assign dout_o = dout_q;
endmodule

module accumulator_bank #(
    parameter int COLS   = 32,
    parameter int DEPTH  = 128,
    parameter int DATA_W = 32,
    parameter int ACC_W  = 32
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    accumulator_bank_if.slave   bus
);
    localparam int            AW       = $clog2(DEPTH);
    localparam logic [AW-1:0] LAST_ROW = AW'(DEPTH - 1);

    typedef enum logic {ST_IDLE = 1'b0, ST_CLEAR = 1'b1} state_e;

    state_e        state_q, state_d;
    logic [AW-1:0] row_q, row_d;
    logic          valid_q, valid_d;

    logic          busy, clr_en, wr_go, rd_go;
    logic [COLS-1:0]            lane_wr;
    logic [COLS-1:0][ACC_W-1:0] rdata;

    // State register: reset lands directly in CLEAR so the bank self-zeroes.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_CLEAR;
            row_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            row_q   <= row_d;
            valid_q <= valid_d;
        end
    end

    // Next state: clear_i is only honoured from IDLE, so a re-pulse mid-clear
    // neither restarts nor extends the sweep.
    always_comb begin
        state_d = state_q;
        row_d   = row_q;
        case (state_q)
            ST_CLEAR: begin
                row_d = row_q + AW'(1);
                if (row_q == LAST_ROW) begin
                    state_d = ST_IDLE;
                    row_d   = '0;
                end
            end
            ST_IDLE: begin
                if (bus.clear_i) begin
                    state_d = ST_CLEAR;
                    row_d   = '0;
                end
            end
            default: begin
                state_d = ST_CLEAR;
                row_d   = '0;
            end
        endcase
    end

`ifdef ACC_SAT_EN
    logic clr_ovf;
`endif

    // Outputs: clear_i in IDLE wins over same-cycle traffic, which is dropped.
    always_comb begin
        busy    = (state_q == ST_CLEAR);
        clr_en  = busy;
        wr_go   = !busy && !bus.clear_i && bus.wr_en_i;
        rd_go   = !busy && !bus.clear_i && bus.rd_en_i;
        valid_d = rd_go;
`ifdef ACC_SAT_EN
        clr_ovf = busy && (row_q == '0);
`endif
    end

    assign lane_wr = bus.col_mask_i & {COLS{wr_go}};

`ifdef ACC_SAT_EN
    logic [COLS-1:0] ovf;
`endif

    for (genvar c = 0; c < COLS; c++) begin : g_lane
        accumulator_bank_lane #(
            .DEPTH  (DEPTH),
            .DATA_W (DATA_W),
            .ACC_W  (ACC_W),
            .AW     (AW),
            .LANE   (c)
        ) u_lane (
            .clk_i      (clk_i),
            .rst_ni     (rst_ni),
            .clr_en_i   (clr_en),
            .clr_row_i  (row_q),
`ifdef ACC_SAT_EN
            .clr_ovf_i  (clr_ovf),
            .ovf_o      (ovf[c]),
`endif
            .wr_en_i    (lane_wr[c]),
            .acc_mode_i (bus.acc_mode_i),
            .addr_wr_i  (bus.addr_wr_i),
            .din_i      (bus.data_i[c]),
            .rd_en_i    (rd_go),
            .addr_rd_i  (bus.addr_rd_i),
            .dout_o     (rdata[c])
        );
    end

    assign bus.busy_o  = busy;
    assign bus.valid_o = valid_q;
    assign bus.data_o  = rdata;
`ifdef ACC_SAT_EN
    assign bus.ovf_o   = ovf;
`else
    assign bus.ovf_o   = '0;
`endif
endmodule

// File: tb/tb_accumulator_bank.sv
module tb_accumulator_bank;
    localparam int COLS   = 32;
    localparam int DEPTH  = 128;
    localparam int DATA_W = 32;
    localparam int ACC_W  = 32;
    localparam int AW     = $clog2(DEPTH);

    typedef logic [COLS-1:0][ACC_W-1:0] row_t;

    logic clk_i = 1'b0;
    logic rst_ni = 1'b0;

    accumulator_bank_if #(.COLS(COLS), .DATA_W(DATA_W), .ACC_W(ACC_W), .AW(AW)) bus ();

    accumulator_bank #(.COLS(COLS), .DEPTH(DEPTH), .DATA_W(DATA_W), .ACC_W(ACC_W)) dut (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .bus    (bus)
    );

    always #5 clk_i = ~clk_i;

    int checks = 0;
    int failures = 0;

    // Reference model
    logic [ACC_W-1:0] m_mem [DEPTH][COLS];
    bit               m_busy;
    int               m_row;
    logic [COLS-1:0]  m_ovf;
    row_t             exp_q[$];

    function automatic int skew(int a, int c);
        return (a - c + DEPTH) % DEPTH;
    endfunction

    function automatic logic [ACC_W-1:0] acc_fn(logic [ACC_W-1:0] old, logic [DATA_W-1:0] d,
                                                output bit ovf);
        longint so, sd, s;
        logic [63:0] sv;
        so = longint'($signed(old));
        sd = longint'($signed(d));
        s  = so + sd;
        ovf = 1'b0;
`ifdef ACC_SAT_EN
        if (s > 64'sd2147483647) begin ovf = 1'b1; return 32'h7FFF_FFFF; end
        if (s < -64'sd2147483648) begin ovf = 1'b1; return 32'h8000_0000; end
`endif
        sv = s;
        return sv[ACC_W-1:0];
    endfunction

    task automatic idle_inputs();
        bus.clear_i    = 1'b0;
        bus.wr_en_i    = 1'b0;
        bus.acc_mode_i = 1'b0;
        bus.col_mask_i = '0;
        bus.addr_wr_i  = '0;
        bus.data_i     = '0;
        bus.rd_en_i    = 1'b0;
        bus.addr_rd_i  = '0;
    endtask

    task automatic model_reset();
        m_busy = 1'b1;
        m_row  = 0;
        m_ovf  = '0;
        exp_q.delete();
    endtask

    // Advance the model by the edge about to happen, then clock the DUT.
    task automatic tick();
        bit o;
        if (rst_ni) begin
            if (m_busy) begin
                for (int c = 0; c < COLS; c++) m_mem[m_row][c] = '0;
                if (m_row == 0) m_ovf = '0;
                if (m_row == DEPTH - 1) begin m_busy = 1'b0; m_row = 0; end
                else m_row++;
            end else if (bus.clear_i) begin
                m_busy = 1'b1;
                m_row  = 0;
            end else begin
                if (bus.rd_en_i) begin
                    row_t r;
                    for (int c = 0; c < COLS; c++) r[c] = m_mem[skew(int'(bus.addr_rd_i), c)][c];
                    exp_q.push_back(r);
                end
                if (bus.wr_en_i) begin
                    for (int c = 0; c < COLS; c++) begin
                        if (bus.col_mask_i[c]) begin
                            int rw;
                            rw = skew(int'(bus.addr_wr_i), c);
                            if (bus.acc_mode_i) begin
                                m_mem[rw][c] = acc_fn(m_mem[rw][c], bus.data_i[c], o);
                                if (o) m_ovf[c] = 1'b1;
                            end else begin
                                m_mem[rw][c] = ACC_W'($signed(bus.data_i[c]));
                            end
                        end
                    end
                end
            end
        end
        @(posedge clk_i);
        #1;
    endtask

    // Scoreboard: every valid_o pops the oldest expected row.
    always @(negedge clk_i) begin
        if (rst_ni) begin
            if (bus.valid_o) begin
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL sb_unexpected_valid t=%0t valid_o=1 required=0", $time);
                end else begin
                    row_t e;
                    int bad;
                    e = exp_q.pop_front();
                    bad = -1;
                    for (int c = COLS - 1; c >= 0; c--) if (bus.data_o[c] !== e[c]) bad = c;
                    if (bad >= 0) begin
                        failures++;
                        $display("FAIL sb_data t=%0t col=%0d got=%h required=%h",
                                 $time, bad, bus.data_o[bad], e[bad]);
                    end
                end
            end else begin
                checks++;
                if (bus.data_o !== '0) begin
                    failures++;
                    $display("FAIL sb_idle_data t=%0t data_o nonzero while valid_o=0", $time);
                end
            end
        end
    end

    task automatic test_reset();
        int n;
        idle_inputs();
        rst_ni = 1'b0;
        model_reset();
        repeat (3) @(posedge clk_i);
        #1;
        checks++; if (bus.busy_o !== 1'b1) begin failures++; $display("FAIL reset_busy got=%b required=1", bus.busy_o); end
        checks++; if (bus.valid_o !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b required=0", bus.valid_o); end
        checks++; if (bus.data_o !== '0) begin failures++; $display("FAIL reset_data got nonzero required=0"); end
        checks++; if (bus.ovf_o !== '0) begin failures++; $display("FAIL reset_ovf got=%h required=0", bus.ovf_o); end
        rst_ni = 1'b1;
        n = 0;
        while (bus.busy_o === 1'b1 && n < 400) begin tick(); n++; end
        checks++; if (n != DEPTH) begin failures++; $display("FAIL autoclear_len got=%0d required=%0d", n, DEPTH); end
        bus.rd_en_i = 1'b1; bus.addr_rd_i = AW'(5);
        tick();
        idle_inputs();
        checks++; if (bus.valid_o !== 1'b1) begin failures++; $display("FAIL first_read_valid got=%b required=1", bus.valid_o); end
        checks++; if (bus.data_o !== '0) begin failures++; $display("FAIL first_read_zero got nonzero required=0"); end
        tick();
    endtask

    task automatic test_overwrite();
        bus.wr_en_i = 1'b1; bus.acc_mode_i = 1'b0; bus.col_mask_i = '1; bus.addr_wr_i = AW'(40);
        for (int c = 0; c < COLS; c++) bus.data_i[c] = DATA_W'(c + 1);
        tick();
        idle_inputs();
        bus.rd_en_i = 1'b1; bus.addr_rd_i = AW'(40);
        tick();
        bus.addr_rd_i = AW'(41);
        checks++; if (bus.data_o[0] !== 32'd1) begin failures++; $display("FAIL ovw_col0 got=%h required=1", bus.data_o[0]); end
        checks++; if (bus.data_o[COLS-1] !== ACC_W'(COLS)) begin failures++; $display("FAIL ovw_collast got=%h required=%h", bus.data_o[COLS-1], COLS); end
        tick();
        idle_inputs();
        checks++; if (bus.data_o[1] !== '0) begin failures++; $display("FAIL ovw_next_row got=%h required=0", bus.data_o[1]); end
        tick();
    endtask

    task automatic test_wrap_mask();
        bus.wr_en_i = 1'b1; bus.col_mask_i = COLS'(8); bus.addr_wr_i = '0;
        for (int c = 0; c < COLS; c++) bus.data_i[c] = DATA_W'(32'h55);
        tick();
        idle_inputs();
        bus.rd_en_i = 1'b1; bus.addr_rd_i = '0;
        tick();
        idle_inputs();
        checks++; if (bus.data_o[3] !== 32'h55) begin failures++; $display("FAIL wrap_col3 got=%h required=55", bus.data_o[3]); end
        checks++; if (bus.data_o[2] !== '0 || bus.data_o[4] !== '0) begin failures++; $display("FAIL mask_other got=%h/%h required=0", bus.data_o[2], bus.data_o[4]); end
        tick();
    endtask

    task automatic test_accum();
        bus.wr_en_i = 1'b1; bus.col_mask_i = '1; bus.addr_wr_i = AW'(60);
        bus.acc_mode_i = 1'b0;
        for (int c = 0; c < COLS; c++) bus.data_i[c] = DATA_W'(100);
        tick();
        bus.acc_mode_i = 1'b1;
        for (int c = 0; c < COLS; c++) bus.data_i[c] = DATA_W'(7);
        tick();
        for (int c = 0; c < COLS; c++) bus.data_i[c] = 32'hFFFF_FFFE;
        tick();
        for (int c = 0; c < COLS; c++) bus.data_i[c] = DATA_W'(10);
        bus.rd_en_i = 1'b1; bus.addr_rd_i = AW'(60);
        tick();
        bus.wr_en_i = 1'b0;
        checks++; if (bus.data_o[0] !== 32'd105) begin failures++; $display("FAIL rmw_preread got=%0d required=105", bus.data_o[0]); end
        tick();
        idle_inputs();
        checks++; if (bus.data_o[COLS-1] !== 32'd115) begin failures++; $display("FAIL rmw_final got=%0d required=115", bus.data_o[COLS-1]); end
        tick();
    endtask

    task automatic test_sat();
        logic [ACC_W-1:0] exp_v;
        logic [COLS-1:0]  exp_o;
`ifdef ACC_SAT_EN
        exp_v = 32'h7FFF_FFFF; exp_o = '1;
`else
        exp_v = 32'h8000_0010; exp_o = '0;
`endif
        bus.wr_en_i = 1'b1; bus.col_mask_i = '1; bus.addr_wr_i = AW'(70); bus.acc_mode_i = 1'b0;
        for (int c = 0; c < COLS; c++) bus.data_i[c] = 32'h7FFF_FFF0;
        tick();
        checks++; if (bus.ovf_o !== '0) begin failures++; $display("FAIL sat_ovw_no_ovf got=%h required=0", bus.ovf_o); end
        bus.acc_mode_i = 1'b1;
        for (int c = 0; c < COLS; c++) bus.data_i[c] = 32'h20;
        tick();
        idle_inputs();
        checks++; if (bus.ovf_o !== exp_o) begin failures++; $display("FAIL sat_ovf got=%h required=%h", bus.ovf_o, exp_o); end
        bus.rd_en_i = 1'b1; bus.addr_rd_i = AW'(70);
        tick();
        idle_inputs();
        checks++; if (bus.data_o[7] !== exp_v) begin failures++; $display("FAIL sat_value got=%h required=%h", bus.data_o[7], exp_v); end
        tick();
    endtask

    task automatic test_clear();
        int n;
        bus.clear_i = 1'b1;
        bus.wr_en_i = 1'b1; bus.col_mask_i = '1; bus.addr_wr_i = AW'(10);
        for (int c = 0; c < COLS; c++) bus.data_i[c] = DATA_W'(9);
        tick();
        idle_inputs();
        n = 1;
        checks++; if (bus.busy_o !== 1'b1) begin failures++; $display("FAIL clear_start_busy got=%b required=1", bus.busy_o); end
        while (n < 400) begin
            if (n == 40) begin
                bus.clear_i = 1'b1; bus.rd_en_i = 1'b1; bus.addr_rd_i = AW'(5);
                bus.wr_en_i = 1'b1; bus.col_mask_i = '1; bus.addr_wr_i = AW'(20);
                for (int c = 0; c < COLS; c++) bus.data_i[c] = DATA_W'(3);
            end
            tick();
            idle_inputs();
            if (n == 2) begin
                checks++; if (bus.ovf_o !== '0) begin failures++; $display("FAIL clear_ovf got=%h required=0", bus.ovf_o); end
            end
            if (bus.busy_o !== 1'b1) break;
            n++;
        end
        checks++; if (n != DEPTH) begin failures++; $display("FAIL clear_len got=%0d required=%0d", n, DEPTH); end
        bus.rd_en_i = 1'b1; bus.addr_rd_i = AW'(10);
        tick();
        bus.addr_rd_i = AW'(20);
        checks++; if (bus.data_o[0] !== '0) begin failures++; $display("FAIL clear_drop_wr got=%h required=0", bus.data_o[0]); end
        tick();
        bus.addr_rd_i = AW'(70);
        checks++; if (bus.data_o[0] !== '0) begin failures++; $display("FAIL busy_drop_wr got=%h required=0", bus.data_o[0]); end
        tick();
        idle_inputs();
        checks++; if (bus.data_o[0] !== '0) begin failures++; $display("FAIL clear_zeroed got=%h required=0", bus.data_o[0]); end
        tick();
    endtask

    task automatic test_reset_midclear();
        int n;
        bus.wr_en_i = 1'b1; bus.col_mask_i = '1; bus.addr_wr_i = AW'(90); bus.acc_mode_i = 1'b0;
        for (int c = 0; c < COLS; c++) bus.data_i[c] = DATA_W'(c + 11);
        tick();
        idle_inputs();
        bus.clear_i = 1'b1;
        tick();
        idle_inputs();
        repeat (30) tick();
        rst_ni = 1'b0;
        #2;
        checks++; if (bus.busy_o !== 1'b1) begin failures++; $display("FAIL midclear_rst_busy got=%b required=1", bus.busy_o); end
        checks++; if (bus.valid_o !== 1'b0) begin failures++; $display("FAIL midclear_rst_valid got=%b required=0", bus.valid_o); end
        model_reset();
        repeat (2) @(posedge clk_i);
        #1;
        rst_ni = 1'b1;
        n = 0;
        while (bus.busy_o === 1'b1 && n < 400) begin tick(); n++; end
        checks++; if (n != DEPTH) begin failures++; $display("FAIL rst_restart_len got=%0d required=%0d", n, DEPTH); end
        bus.rd_en_i = 1'b1; bus.addr_rd_i = AW'(90);
        tick();
        idle_inputs();
        checks++; if (bus.data_o[4] !== '0) begin failures++; $display("FAIL rst_clear_row got=%h required=0", bus.data_o[4]); end
        tick();
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 400; i++) begin
            bus.wr_en_i    = ($urandom_range(0, 2) != 0);
            bus.acc_mode_i = ($urandom_range(0, 3) != 0);
            bus.col_mask_i = COLS'($urandom());
            bus.addr_wr_i  = AW'($urandom_range(0, 15));
            bus.rd_en_i    = ($urandom_range(0, 1) != 0);
            bus.addr_rd_i  = AW'($urandom_range(0, 15));
            for (int c = 0; c < COLS; c++)
                bus.data_i[c] = ($urandom_range(0, 3) == 0) ? DATA_W'($urandom())
                                                            : DATA_W'($urandom_range(0, 2000) - 1000);
            tick();
            checks++;
            if (bus.ovf_o !== m_ovf) begin
                failures++;
                $display("FAIL rand_ovf i=%0d got=%h required=%h", i, bus.ovf_o, m_ovf);
            end
        end
        idle_inputs();
        tick();
        tick();
        checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL sb_missing_reads got=%0d outstanding required=0", exp_q.size()); end
    endtask

    initial begin
        for (int r = 0; r < DEPTH; r++)
            for (int c = 0; c < COLS; c++) m_mem[r][c] = 'x;
        test_reset();
        test_overwrite();
        test_wrap_mask();
        test_accum();
        test_sat();
        test_clear();
        test_reset_midclear();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/accumulator_bank.md
# accumulator_bank

Parametrised successor to the systolic-array output accumulator: a COLS-wide, DEPTH-deep register-file bank that takes one skewed result row per cycle from the MAC array. Each word is either overwritten or accumulated (read-modify-write) in a single cycle. The block has a registered, skewed read port with a valid strobe, a self-sequencing clear engine that also runs automatically after reset, and optional signed saturation with sticky per-column overflow flags. It sits between the systolic array and the unified buffer write-back path.

## Interface
- COLS, 32, number of columns/lanes (≥1)
- DEPTH, 128, rows per column; power of two, ≥ COLS
- DATA_W, 32, input element width (signed two's complement)
- ACC_W, 32, stored/output width; ACC_W ≥ DATA_W
- AW, $clog2(DEPTH), address width (derived, not overridable)

Ports:
- clk_i  in  1  clock, all state on rising edge
- rst_ni  in  1  asynchronous, active-low reset
- clear_i  in  1  pulse: start clear of whole bank (ignored while busy_o)
- busy_o  out  1  clear engine running; wr/rd ignored
- wr_en_i  in  1  write row request
- acc_mode_i  in  1  1 = accumulate, 0 = overwrite
- col_mask_i  in  COLS  per-column write enable
- addr_wr_i  in  AW  write base address
- data_i  in  COLS×DATA_W  column data
- rd_en_i  in  1  read row request
- addr_rd_i  in  AW  read base address
- data_o  out  COLS×ACC_W  read data, zero when valid_o=0
- valid_o  out  1  data_o valid
- ovf_o  out  COLS  sticky overflow per column

## Operation
- Skew: column c accesses row (addr − c) mod DEPTH, for both write and read; wrap-around is modulo DEPTH, not clamped.
- Write (wr_en_i=1, IDLE): for every c with col_mask_i[c]=1, new = acc_mode_i ? mem[row][c] + sext(data_i[c]) : sext(data_i[c]). Columns with the mask bit clear are untouched.
- Read (rd_en_i=1, IDLE): data_o[c] ← mem[(addr_rd_i − c) mod DEPTH][c], registered.
- Simultaneous read and write of the same cell: the read returns the pre-write value.
- FSM states:
  - CLEAR: entered on reset deassertion, and from IDLE on clear_i. Row counter k runs 0→DEPTH−1. Each cycle, all columns of row k are zeroed. ovf_o is cleared on the first CLEAR cycle. After k=DEPTH−1, next state is IDLE.
  - IDLE: normal operation.
- clear_i in IDLE has priority over same-cycle wr_en_i/rd_en_i; those requests are dropped. clear_i during CLEAR is ignored; no restart.
- rd_en_i/wr_en_i during CLEAR are dropped: no valid_o, no storage change.
- Reset asserted mid-clear or mid-traffic: control returns to reset values immediately. Storage is not reset by rst_ni; the auto-clear after release zeroes it.

## Timing
- Reset values: busy_o=1 (CLEAR, k=0), valid_o=0, data_o=0, ovf_o=0.
- Auto-clear occupies DEPTH cycles after reset release; busy_o falls on the edge after row DEPTH−1 is cleared.
- Write latency: storage updates at the sampling edge. A read sampled on the next edge sees the new value.
- Back-to-back accumulates to the same cell on consecutive cycles are exact; the single-cycle RMW needs no forwarding.
- Read latency: 1 cycle. rd_en_i sampled at edge t gives valid_o=1 and data_o during cycle t+1. Reads can be issued every cycle.
- ovf_o bits update at the same edge as the offending write.

## Configuration
- ACC_SAT_EN defined:
  - Accumulation saturates to the signed ACC_W range [−2^(ACC_W−1), 2^(ACC_W−1)−1].
  - Any saturating write sets ovf_o[c]; it stays set until the next clear.
  - Overwrite mode never saturates.
- ACC_SAT_EN undefined:
  - Accumulation wraps modulo 2^ACC_W.
  - ovf_o is tied to 0 and the overflow logic is absent.

## Test plan
- Reset release → busy_o=1 for exactly 128 cycles, then 0. A read of addr 5 then returns all zeros with valid_o=1 one cycle later.
- Overwrite all columns at addr 40 with data_i[c]=c+1, then read addr 40 → data_o[c]=c+1 for all c. Read addr 41 → zeros.
- Wrap and mask: addr_wr 0, col_mask=0x8, data 0x55 → cell row 125 col 3 = 0x55. Read addr 0 → data_o[3]=0x55, all other columns 0.
- Accumulate 3 consecutive cycles at addr 60 with data 7, −2, 10 (after an overwrite of 100) → read gives 115. Same-cycle read during the third write returns 105.
- ACC_SAT_EN: overwrite 0x7FFFFFF0, accumulate 0x20 → 0x7FFFFFFF and ovf_o[c]=1. Without the macro → 0x80000010 and ovf_o=0. Clear → ovf_o=0.
- clear_i together with wr_en_i at addr 10 → write dropped, busy_o=1 for 128 cycles. Re-pulsing clear_i mid-clear does not extend it. Asserting rst_ni low mid-clear restarts the clear from row 0.
